// File: rtl/field_mul_arbiter.sv
// Round-robin arbiter sharing one field multiplier among NREQ requesters.
// Define FIELD_MUL_ARB_STATS_EN to add the stat_ops/stat_busy counters.
`ifndef F_NBITS
`define F_NBITS 16
`endif

module field_mul_arbiter #(
    parameter int NREQ  = 4,
    parameter int NBITS = `F_NBITS
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*NBITS-1:0] a_in,
    input  logic [NREQ*NBITS-1:0] b_in,
    output logic [NREQ-1:0]       ack,
    output logic [NREQ-1:0]       done,
    output logic [NBITS-1:0]      c_out,
    output logic                  busy,
    output logic                  mul_en,
    output logic [NBITS-1:0]      mul_a,
    output logic [NBITS-1:0]      mul_b,
    input  logic                  mul_ready_pulse,
    input  logic [NBITS-1:0]      mul_c
`ifdef FIELD_MUL_ARB_STATS_EN
    ,
    output logic [31:0]           stat_ops,
    output logic [31:0]           stat_busy
`endif
);

    localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [LW-1:0]    r_last;
    logic [LW-1:0]    r_gid;
    logic [NREQ-1:0]  r_ack;
    logic [NREQ-1:0]  r_done;
    logic             r_en;
    logic [NBITS-1:0] r_c;
    logic [NBITS-1:0] r_a;
    logic [NBITS-1:0] r_b;

    logic             w_found;
    logic [LW-1:0]    w_win;
    logic [LW:0]      w_idx;
    logic [NBITS-1:0] w_a;
    logic [NBITS-1:0] w_b;

    // Search starts just past the last winner and wraps modulo NREQ.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = {1'b0, r_last} + (LW+1)'(k);
            if (w_idx >= (LW+1)'(NREQ)) begin
                w_idx = w_idx - (LW+1)'(NREQ);
            end
            if (!w_found && req[w_idx[LW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[LW-1:0];
            end
        end
    end

    assign w_a = a_in[w_win*NBITS +: NBITS];
    assign w_b = b_in[w_win*NBITS +: NBITS];

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state <= S_IDLE;
            r_last  <= LW'(NREQ-1);
            r_gid   <= '0;
            r_ack   <= '0;
            r_done  <= '0;
            r_en    <= 1'b0;
            r_c     <= '0;
            r_a     <= '0;
            r_b     <= '0;
        end else begin
            r_ack  <= '0;
            r_done <= '0;
            r_en   <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_a     <= w_a;
                        r_b     <= w_b;
                        r_gid   <= w_win;
                        r_last  <= w_win;
                        r_ack   <= NREQ'(1) << w_win;
                        r_en    <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: r_state <= S_WAIT;
                S_WAIT: begin
                    if (mul_ready_pulse) begin
                        r_c     <= mul_c;
                        r_done  <= NREQ'(1) << r_gid;
                        r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ack    = r_ack;
    assign done   = r_done;
    assign c_out  = r_c;
    assign mul_en = r_en;
    assign mul_a  = r_a;
    assign mul_b  = r_b;
    assign busy   = (r_state != S_IDLE);

`ifdef FIELD_MUL_ARB_STATS_EN
    logic [31:0] r_stat_ops;
    logic [31:0] r_stat_busy;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_stat_ops  <= '0;
            r_stat_busy <= '0;
        end else begin
            if (|r_done) begin
                r_stat_ops <= r_stat_ops + 32'd1;
            end
            if (r_state != S_IDLE) begin
                r_stat_busy <= r_stat_busy + 32'd1;
            end
        end
    end

    assign stat_ops  = r_stat_ops;
    assign stat_busy = r_stat_busy;
`endif

endmodule

// File: tb/tb_field_mul_arbiter.sv
// Bench for field_mul_arbiter: directed scenarios plus random traffic,
// checked against a transaction-level model with a behavioural multiplier.
module tb_field_mul_arbiter;

    localparam int NREQ  = 4;
    localparam int NBITS = 16;
    localparam longint P = 65521;

    logic        clk = 1'b0;
    logic        rstb = 1'b1;
    logic [3:0]  req = '0;
    logic [63:0] a_in = '0;
    logic [63:0] b_in = '0;
    logic [3:0]  ack;
    logic [3:0]  done;
    logic [15:0] c_out;
    logic        busy;
    logic        mul_en;
    logic [15:0] mul_a;
    logic [15:0] mul_b;
    logic        mul_ready_pulse;
    logic [15:0] mul_c;
`ifdef FIELD_MUL_ARB_STATS_EN
    logic [31:0] stat_ops;
    logic [31:0] stat_busy;
`endif

    field_mul_arbiter #(.NREQ(NREQ), .NBITS(NBITS)) dut (
        .clk(clk),
        .rstb(rstb),
        .req(req),
        .a_in(a_in),
        .b_in(b_in),
        .ack(ack),
        .done(done),
        .c_out(c_out),
        .busy(busy),
        .mul_en(mul_en),
        .mul_a(mul_a),
        .mul_b(mul_b),
        .mul_ready_pulse(mul_ready_pulse),
        .mul_c(mul_c)
`ifdef FIELD_MUL_ARB_STATS_EN
        ,
        .stat_ops(stat_ops),
        .stat_busy(stat_busy)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] fmul(input logic [15:0] x, input logic [15:0] y);
        longint t;
        t = (longint'(x) * longint'(y)) % P;
        return 16'(t);
    endfunction

    // Behavioural multiplier with random latency
    logic        m_rdy = 1'b0;
    logic [15:0] m_c = '0;
    int          m_cnt = 0;
    logic        f_rdy = 1'b0;
    logic [15:0] f_c = '0;

    always @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            m_cnt <= 0;
            m_rdy <= 1'b0;
            m_c   <= '0;
        end else begin
            m_rdy <= 1'b0;
            if (mul_en) begin
                m_cnt <= int'($urandom_range(1, 4));
            end else if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_rdy <= 1'b1;
                    m_c   <= fmul(mul_a, mul_b);
                end
            end
        end
    end

    assign mul_ready_pulse = m_rdy | f_rdy;
    assign mul_c = f_rdy ? f_c : m_c;

    // What the DUT saw at the last rising edge
    logic [3:0]  s_req = '0;
    logic [63:0] s_a = '0;
    logic [63:0] s_b = '0;
    logic        s_rdy = 1'b0;
    logic        s_rstb = 1'b0;

    always @(posedge clk) begin
        s_req  <= req;
        s_a    <= a_in;
        s_b    <= b_in;
        s_rdy  <= mul_ready_pulse;
        s_rstb <= rstb;
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rr(input logic [3:0] r, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    // Transaction-level model state
    int          cyc = 0;
    int          last = NREQ - 1;
    bit          in_op = 1'b0;
    int          op_id = 0;
    int          ack_cyc = 0;
    int          free_at = 0;
    logic [15:0] op_a = '0;
    logic [15:0] op_b = '0;
    logic [15:0] exp_c = '0;
    int          b_ops = 0;
    int          b_busy = 0;
    int          n_ack = 0;
    int          n_done = 0;
    int          g_q[$];
    int          c_q[$];
    logic [3:0]  keep = '0;
    bit          rnd_mode = 1'b0;

    task automatic step();
        logic [3:0] e_ack;
        logic [3:0] e_done;
        bit         e_busy;
        int         w;
        @(negedge clk);
        cyc++;
        e_ack  = '0;
        e_done = '0;
        if (!rstb) begin
            in_op   = 1'b0;
            last    = NREQ - 1;
            exp_c   = '0;
            free_at = 0;
            b_ops   = 0;
            b_busy  = 0;
        end else if (s_rstb && !in_op && cyc >= free_at && s_req != 0) begin
            w       = rr(s_req, last);
            last    = w;
            e_ack   = 4'(1 << w);
            in_op   = 1'b1;
            op_id   = w;
            ack_cyc = cyc;
            op_a    = s_a[w*16 +: 16];
            op_b    = s_b[w*16 +: 16];
        end else if (in_op && cyc >= ack_cyc + 2 && s_rdy) begin
            e_done  = 4'(1 << op_id);
            exp_c   = fmul(op_a, op_b);
            in_op   = 1'b0;
            free_at = cyc + 2;
        end
        e_busy = in_op || (e_done != 0);
        chk("ack", 32'(ack), 32'(e_ack));
        chk("mul_en", 32'(mul_en), 32'(e_ack != 0));
        chk("done", 32'(done), 32'(e_done));
        chk("c_out", 32'(c_out), 32'(exp_c));
        chk("busy", 32'(busy), 32'(e_busy));
        if (e_ack != 0) begin
            chk("mul_a", 32'(mul_a), 32'(op_a));
            chk("mul_b", 32'(mul_b), 32'(op_b));
        end
`ifdef FIELD_MUL_ARB_STATS_EN
        chk("stat_ops", stat_ops, 32'(b_ops));
        chk("stat_busy", stat_busy, 32'(b_busy));
`endif
        if (rstb) begin
            b_ops  += (e_done != 0) ? 1 : 0;
            b_busy += e_busy ? 1 : 0;
        end
        if (ack != 0) n_ack++;
        if (done != 0) begin
            n_done++;
            c_q.push_back(int'(c_out));
        end
        for (int i = 0; i < NREQ; i++) begin
            if (ack[i]) g_q.push_back(i);
            if (ack[i] && !keep[i]) req[i] = 1'b0;
        end
        if (rnd_mode) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    a_in[i*16 +: 16] = 16'($urandom);
                    b_in[i*16 +: 16] = 16'($urandom);
                end
            end
        end
        f_rdy = 1'b0;
    endtask

    task automatic serve(input int nops);
        int ta;
        int td;
        int k;
        ta = n_ack + nops;
        td = n_done + nops;
        k  = 0;
        while (n_done < td && k < 300) begin
            step();
            if (n_ack >= ta) begin
                keep = '0;
                req  = '0;
            end
            k++;
        end
        chk("serve_timeout", 32'(n_done >= td), 32'd1);
        step();
        step();
    endtask

    task automatic do_reset();
        rstb = 1'b0;
        step();
        step();
        rstb = 1'b1;
        step();
    endtask

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
        a_in[i*16 +: 16] = a;
        b_in[i*16 +: 16] = b;
        req[i] = 1'b1;
    endtask

    initial begin
        int exp_g[5];
        int exp_cs[5];
        int a0;
        int d0;
        int k;
        exp_g  = '{0, 1, 2, 3, 0};
        exp_cs = '{2, 4, 6, 8, 2};
        #1 rstb = 1'b0;
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mul_a", 32'(mul_a), 32'd0);
        chk("rst_mul_b", 32'(mul_b), 32'd0);
        chk("rst_c_out", 32'(c_out), 32'd0);
        step();
        rstb = 1'b1;
        step();

        // Single request
        g_q.delete();
        c_q.delete();
        set_op(2, 16'd3, 16'd5);
        serve(1);
        chk("s1_grant", 32'(g_q.size() > 0 ? g_q[0] : -1), 32'd2);
        chk("s1_c", 32'(c_q.size() > 0 ? c_q[0] : -1), 32'd15);

        // Round-robin with all requests held
        do_reset();
        g_q.delete();
        c_q.delete();
        for (int i = 0; i < NREQ; i++) set_op(i, 16'(i + 1), 16'd2);
        keep = 4'b1111;
        serve(5);
        chk("s2_count", 32'(g_q.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            chk("s2_grant", 32'(g_q.size() > i ? g_q[i] : -1), 32'(exp_g[i]));
            chk("s2_c", 32'(c_q.size() > i ? c_q[i] : -1), 32'(exp_cs[i]));
        end
`ifdef FIELD_MUL_ARB_STATS_EN
        chk("s6_stat_ops", stat_ops, 32'd5);
        chk("s6_stat_busy", stat_busy, 32'(b_busy));
`endif

        // Pointer rotation
        set_op(2, 16'd1, 16'd1);
        serve(1);
        g_q.delete();
        set_op(0, 16'd10, 16'd3);
        set_op(2, 16'd11, 16'd3);
        serve(2);
        chk("s3_first", 32'(g_q.size() > 0 ? g_q[0] : -1), 32'd0);
        chk("s3_second", 32'(g_q.size() > 1 ? g_q[1] : -1), 32'd2);

        // Reset while waiting for the multiplier
        a0 = n_ack;
        set_op(1, 16'd9, 16'd9);
        k = 0;
        while (n_ack == a0 && k < 20) begin
            step();
            k++;
        end
        chk("s4_ack_seen", 32'(n_ack - a0), 32'd1);
        step();
        d0 = n_done;
        rstb = 1'b0;
        #1;
        chk("s4_busy", 32'(busy), 32'd0);
        chk("s4_c_out", 32'(c_out), 32'd0);
        step();
        step();
        rstb = 1'b1;
        repeat (6) step();
        chk("s4_no_done", 32'(n_done), 32'(d0));
        g_q.delete();
        c_q.delete();
        set_op(0, 16'd4, 16'd6);
        serve(1);
        chk("s4_grant", 32'(g_q.size() > 0 ? g_q[0] : -1), 32'd0);
        chk("s4_c", 32'(c_q.size() > 0 ? c_q[0] : -1), 32'd24);

        // Spurious ready while idle
        d0 = n_done;
        f_c = 16'd7;
        f_rdy = 1'b1;
        step();
        step();
        chk("s5_done", 32'(n_done), 32'(d0));
        chk("s5_c_out", 32'(c_out), 32'd24);

        // Random traffic
        rnd_mode = 1'b1;
        repeat (600) step();
        rnd_mode = 1'b0;
        k = 0;
        while ((req != 0 || in_op) && k < 600) begin
            step();
            k++;
        end
        chk("drain", 32'(req != 0 || in_op), 32'd0);
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
